// File: rtl/aes_loader_pkg.sv
// -----------------------------------------------------------------------------
// aes_loader_pkg
// Shared definitions for the AES frame loader: FSM state encoding, key-size
// mode codes, error codes and the key-length helper.
// -----------------------------------------------------------------------------
package aes_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEY   = 3'd1,
        DATA  = 3'd2,
        START = 3'd3,
        BUSY  = 3'd4
    } state_e;

    localparam logic [1:0] MODE_128 = 2'd0;
    localparam logic [1:0] MODE_192 = 2'd1;
    localparam logic [1:0] MODE_256 = 2'd2;

    localparam logic [1:0] ERR_HDR   = 2'd1;
    localparam logic [1:0] ERR_REUSE = 2'd2;
    localparam logic [1:0] ERR_TMO   = 2'd3;

    // Number of key bytes carried in a frame for a given key-size mode.
    function automatic logic [5:0] key_bytes(input logic [1:0] mode);
        case (mode)
            MODE_128: key_bytes = 6'd16;
            MODE_192: key_bytes = 6'd24;
            default:  key_bytes = 6'd32;
        endcase
    endfunction

endpackage

// File: rtl/aes_frame_loader.sv
// -----------------------------------------------------------------------------
// aes_frame_loader
// Byte-stream front end of the AES core. Accepts a framed command
// (header, 16/24/32 key bytes unless the key is reused, 16 block bytes) over a
// valid/ready byte interface, assembles the 128-bit block and the left-justified
// 256-bit key, pulses start for one cycle and then waits for done (or a timeout).
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   s_data/s_valid  input byte stream; s_ready high in IDLE, KEY and DATA
//   abort           synchronous abort back to IDLE
//   done            AES core finished the current frame (used only in BUSY)
//   blk_out         block, first byte at [127:120]
//   key_out         key, first byte at [255:248], unused low bytes zero
//   mode_out/op_out key size (0=128,1=192,2=256) and direction (1=decrypt)
//   start           one-cycle pulse when a frame is ready
//   busy            high in START and BUSY
//   key_valid       key_out holds a complete key for mode_out
//   err/err_code    one-cycle error pulse; code held until the next error
// -----------------------------------------------------------------------------
module aes_frame_loader
    import aes_loader_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         abort,
    input  logic         done,
    output logic [127:0] blk_out,
    output logic [255:0] key_out,
    output logic [1:0]   mode_out,
    output logic         op_out,
    output logic         start,
    output logic         busy,
    output logic         key_valid,
    output logic         err,
    output logic [1:0]   err_code
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]   tmo_q, tmo_d;
    logic [127:0]       blk_q, blk_d;
    logic [255:0]       key_q, key_d;
    logic [1:0]         mode_q, mode_d;
    logic               op_q, op_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               kv_q, kv_d;
    logic               err_q, err_d;
    logic [1:0]         code_q, code_d;

    logic               xfer;
    logic [1:0]         hdr_mode;
    logic [5:0]         kb_last;

    // Ready is forced low while reset is asserted, independent of the state.
    assign s_ready  = !rst && (state_q == IDLE || state_q == KEY || state_q == DATA);
    assign xfer     = s_valid && s_ready;
    assign hdr_mode = s_data[1:0];
    assign kb_last  = key_bytes(mode_q) - 6'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        blk_d   = blk_q;
        key_d   = key_q;
        mode_d  = mode_q;
        op_d    = op_q;
        kv_d    = kv_q;
        code_d  = code_q;
        start_d = 1'b0;
        err_d   = 1'b0;

        if (abort) begin
            // Abort wins over any byte presented in the same cycle.
            state_d = IDLE;
            cnt_d   = '0;
            tmo_d   = '0;
            if (state_q == KEY) begin
                key_d = '0;
                kv_d  = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        cnt_d = '0;
                        if (hdr_mode == 2'd3 || s_data[7:4] != 4'd0) begin
                            err_d  = 1'b1;
                            code_d = ERR_HDR;
                        end else if (s_data[3]) begin
                            // Reuse is only legal with a complete key of the same size.
                            if (!kv_q || hdr_mode != mode_q) begin
                                err_d  = 1'b1;
                                code_d = ERR_REUSE;
                            end else begin
                                op_d    = s_data[2];
                                state_d = DATA;
                            end
                        end else begin
                            mode_d  = hdr_mode;
                            op_d    = s_data[2];
                            key_d   = '0;
                            kv_d    = 1'b0;
                            state_d = KEY;
                        end
                    end
                end
                KEY: begin
                    if (xfer) begin
                        key_d[255 - 8*int'(cnt_q) -: 8] = s_data;
                        if ({1'b0, cnt_q} == kb_last) begin
                            kv_d    = 1'b1;
                            cnt_d   = '0;
                            state_d = DATA;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        blk_d[127 - 8*int'(cnt_q) -: 8] = s_data;
                        if (cnt_q == 5'd15) begin
                            cnt_d   = '0;
                            start_d = 1'b1;
                            state_d = START;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end
                START: begin
                    tmo_d   = '0;
                    state_d = BUSY;
                end
                BUSY: begin
                    // done is checked first so a coincident timeout is not reported.
                    if (done) begin
                        tmo_d   = '0;
                        state_d = IDLE;
                    end else if (tmo_q == TMO_LAST) begin
                        tmo_d   = '0;
                        err_d   = 1'b1;
                        code_d  = ERR_TMO;
                        state_d = IDLE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end
            endcase
        end

        busy_d = (state_d == START) || (state_d == BUSY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            blk_q   <= '0;
            key_q   <= '0;
            mode_q  <= '0;
            op_q    <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            kv_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            blk_q   <= blk_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            op_q    <= op_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            kv_q    <= kv_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign blk_out   = blk_q;
    assign key_out   = key_q;
    assign mode_out  = mode_q;
    assign op_out    = op_q;
    assign start     = start_q;
    assign busy      = busy_q;
    assign key_valid = kv_q;
    assign err       = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_aes_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_aes_frame_loader
// Directed bench for aes_frame_loader with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_aes_frame_loader;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   s_data = 8'h00;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic         abort = 1'b0;
    logic         done = 1'b0;
    logic [127:0] blk_out;
    logic [255:0] key_out;
    logic [1:0]   mode_out;
    logic         op_out;
    logic         start;
    logic         busy;
    logic         key_valid;
    logic         err;
    logic [1:0]   err_code;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [255:0] KEY256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY128 =
        {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] BLK_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] BLK_B = 128'hffeeddccbbaa99887766554433221100;

    always #5 clk = ~clk;

    aes_frame_loader #(.TIMEOUT(64), .CNT_W(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .abort     (abort),
        .done      (done),
        .blk_out   (blk_out),
        .key_out   (key_out),
        .mode_out  (mode_out),
        .op_out    (op_out),
        .start     (start),
        .busy      (busy),
        .key_valid (key_valid),
        .err       (err),
        .err_code  (err_code)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one byte; returns #1 after the edge that transfers it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        s_data  = b;
        s_valid = 1'b1;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("ready_wait", {255'b0, s_ready}, 256'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values while rst is high
        #2;
        chk("rst_s_ready", {255'b0, s_ready}, 256'd0);
        chk("rst_key", key_out, 256'd0);
        chk("rst_blk", {128'b0, blk_out}, 256'd0);
        chk("rst_flags", {248'b0, start, busy, key_valid, err, err_code, mode_out},
            256'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {255'b0, s_ready}, 256'd1);

        // Header errors
        send_byte(8'h03);
        chk("hdr03_err", {253'b0, err, err_code}, {253'b0, 1'b1, 2'd1});
        tick(1);
        chk("hdr03_pulse", {255'b0, err}, 256'd0);
        send_byte(8'h10);
        chk("hdr10_err", {253'b0, err, err_code}, {253'b0, 1'b1, 2'd1});
        send_byte(8'h0A);
        chk("hdr0a_err", {253'b0, err, err_code}, {253'b0, 1'b1, 2'd2});
        chk("hdr_idle", {253'b0, s_ready, start, key_valid}, {253'b0, 3'b100});

        // 256-bit key load
        send_byte(8'h02);
        for (int i = 0; i < 32; i++) send_byte(8'(i));
        chk("k256_kv", {255'b0, key_valid}, 256'd1);
        for (int i = 0; i < 16; i++) send_byte(8'(i * 17));
        chk("k256_start", {254'b0, start, s_ready}, {254'b0, 2'b10});
        chk("k256_key", key_out, KEY256);
        chk("k256_blk", {128'b0, blk_out}, {128'b0, BLK_A});
        chk("k256_mode", {253'b0, mode_out, op_out}, {253'b0, 2'd2, 1'b0});
        tick(1);
        chk("k256_1cyc", {253'b0, start, busy, s_ready}, {253'b0, 3'b010});
        tick(5);
        chk("k256_hold", {254'b0, busy, s_ready}, {254'b0, 2'b10});
        pulse_done();
        chk("k256_done", {254'b0, busy, s_ready}, {254'b0, 2'b01});

        // Key reuse: 0x0E = mode 2, decrypt, reuse
        send_byte(8'h0E);
        for (int i = 0; i < 15; i++) send_byte(8'hff ^ 8'(i * 17));
        chk("reuse_nostart", {255'b0, start}, 256'd0);
        send_byte(8'h00);
        chk("reuse_start", {255'b0, start}, 256'd1);
        chk("reuse_op", {253'b0, mode_out, op_out}, {253'b0, 2'd2, 1'b1});
        chk("reuse_key", key_out, KEY256);
        chk("reuse_blk", {128'b0, blk_out}, {128'b0, BLK_B});
        pulse_done();

        // Timeout: start at edge E0, BUSY count 63 reached after E64, err after E65
        send_byte(8'h0A);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        chk("tmo_start", {255'b0, start}, 256'd1);
        tick(64);
        chk("tmo_before", {254'b0, err, busy}, {254'b0, 2'b01});
        tick(1);
        chk("tmo_err", {252'b0, err, err_code, busy}, {252'b0, 1'b1, 2'd3, 1'b0});
        chk("tmo_idle", {255'b0, s_ready}, 256'd1);

        // done in the same cycle as the timeout: no error
        send_byte(8'h0A);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        tick(64);
        pulse_done();
        chk("tmo_done_win", {254'b0, err, busy}, {254'b0, 2'b00});
        chk("tmo_done_code", {254'b0, err_code}, {254'b0, 2'd3});

        // Abort after 5 key bytes
        send_byte(8'h02);
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_kv", {255'b0, key_valid}, 256'd0);
        chk("abort_key", key_out, 256'd0);
        chk("abort_ready", {255'b0, s_ready}, 256'd1);
        send_byte(8'h03);
        chk("abort_idle_hdr", {253'b0, err, err_code}, {253'b0, 1'b1, 2'd1});

        // 128-bit key load
        send_byte(8'h00);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        for (int i = 0; i < 16; i++) send_byte(8'(i * 17));
        chk("k128_start", {255'b0, start}, 256'd1);
        chk("k128_key", key_out, KEY128);
        chk("k128_mode", {253'b0, mode_out, key_valid}, {253'b0, 2'd0, 1'b1});
        pulse_done();

        // Reset in the middle of DATA (0x08 = reuse 128-bit key)
        send_byte(8'h08);
        for (int i = 0; i < 5; i++) send_byte(8'h55);
        rst = 1'b1;
        #2;
        chk("mrst_key", key_out, 256'd0);
        chk("mrst_blk", {128'b0, blk_out}, 256'd0);
        chk("mrst_flags",
            {247'b0, s_ready, start, busy, key_valid, err, err_code, mode_out}, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_release", {255'b0, s_ready}, 256'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
